// File: rtl/bcd_disp_pkg.sv
// Shared constants for the seven-segment display driver: blank/dash patterns,
// the active-low digit pattern table and the conversion FSM encoding.
package bcd_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Active-low gfedcba patterns, digit d at SEG_TABLE[7*d +: 7]
  localparam logic [69:0] SEG_TABLE = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low 7-segment pattern; blank forces all segments off.
module seg7_decode
  import bcd_disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank && digit <= 4'd9)
      seg = SEG_TABLE[7*int'(digit) +: 7];
  end

endmodule

// File: rtl/bcd_display_seq.sv
// Iterative double-dabble binary-to-7-segment driver, one operand bit per clock,
// with sign digit, leading-zero blanking and overflow dashes on registered outputs.
module bcd_display_seq
  import bcd_disp_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DIGITS   = 5,
  parameter int BLANK_LZ = 1,
  parameter int SIGN_EN  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  input  logic                  is_signed,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   seg,
  output logic [6:0]            seg_sign
);

  localparam int CW = $clog2(WIDTH);
  localparam int BW = 4 * DIGITS;

  state_t               state;
  logic [CW-1:0]        count;
  logic [WIDTH-1:0]     mag;
  logic [BW-1:0]        bcd;
  logic                 ovf_st;
  logic                 neg;

  logic [BW-1:0]        bcd_adj;
  logic [BW-1:0]        bcd_nxt;
  logic                 ovf_nxt;
  logic [DIGITS-1:0]    blank_d;
  logic [7*DIGITS-1:0]  seg_dec;
  logic                 signed_mode;

  assign signed_mode = is_signed && (SIGN_EN != 0);

  // One double-dabble step; the outputs are decoded from the post-step value so
  // they can be registered on the same edge that performs the final shift.
  always_comb begin
    bcd_adj = '0;
    for (int k = 0; k < DIGITS; k++)
      bcd_adj[4*k +: 4] = add3(bcd[4*k +: 4]);
    bcd_nxt = {bcd_adj[BW-2:0], mag[WIDTH-1]};
    ovf_nxt = ovf_st | bcd_adj[BW-1];
  end

  always_comb begin
    logic any_nz;
    any_nz  = 1'b0;
    blank_d = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      any_nz     = any_nz | (bcd_nxt[4*k +: 4] != 4'd0);
      blank_d[k] = (BLANK_LZ != 0) && (k != 0) && !any_nz;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seg7_decode u_dec (
      .digit (bcd_nxt[4*g +: 4]),
      .blank (blank_d[g]),
      .seg   (seg_dec[7*g +: 7])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      mag      <= '0;
      bcd      <= '0;
      ovf_st   <= 1'b0;
      neg      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      seg      <= {DIGITS{SEG_BLANK}};
      seg_sign <= SEG_BLANK;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // A negative operand always has a nonzero magnitude, so neg alone rules out "-0"
            neg    <= signed_mode && bin[WIDTH-1];
            mag    <= (signed_mode && bin[WIDTH-1]) ? -bin : bin;
            bcd    <= '0;
            ovf_st <= 1'b0;
            count  <= CW'(WIDTH - 1);
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          bcd    <= bcd_nxt;
          ovf_st <= ovf_nxt;
          mag    <= {mag[WIDTH-2:0], 1'b0};
          if (count == '0) begin
            state    <= LOAD;
            done     <= 1'b1;
            overflow <= ovf_nxt;
            seg      <= ovf_nxt ? {DIGITS{SEG_DASH}} : seg_dec;
            seg_sign <= (neg && !ovf_nxt) ? SEG_DASH : SEG_BLANK;
          end else begin
            count <= count - 1'b1;
          end
        end
        LOAD: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
